// File: rtl/dct_zigzag_serializer.sv
// rtl/dct_zigzag_serializer.sv - ping-pong 8x8 block buffer drained in JPEG zigzag order
// Columns land as bursts of 8 vectors; coefficients leave one per beat on a valid/ready stream.
module dct_zigzag_serializer #(
   parameter int BW = 12
) (
   input  logic            i_clk,
   input  logic            i_Reset,
   input  logic [8*BW-1:0] i_data,
   input  logic            i_enable,
   input  logic            i_ready,
   output logic [BW-1:0]   o_data,
   output logic            o_valid,
   output logic            o_last,
   output logic            o_overflow
);

   // Zigzag position n -> raster index (row*8+col); entry 0 sits in the MSBs.
   localparam logic [6*64-1:0] ZZ_TABLE = {
      6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
      6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
      6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
      6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
      6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
      6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
      6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
      6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
   };

   logic [BW-1:0] mem [0:1][0:63];

   logic [2:0] ic;
   logic       drop_q;
   logic       wp;
   logic       rp;
   logic [1:0] full;
   logic [5:0] n;
   logic       done;

   logic       release_blk;
   logic       burst_ok;
   logic       drop_now;
   logic       wr_en;
   logic       rd_bank;
   logic [5:0] rd_n;
   logic       rd_avail;
   logic       load;
   logic [5:0] zz_pos;
   logic [8:0] zz_bit;
   logic [5:0] rd_addr;

   assign release_blk = o_valid & i_ready & o_last;
   assign burst_ok    = !full[wp] || (release_blk && (rp == wp));
   assign drop_now    = (ic == 3'd0) ? !burst_ok : drop_q;
   assign wr_en       = i_enable && !drop_now;

   // On release the next bank is read in the same cycle so blocks stream without a bubble.
   assign rd_bank  = release_blk ? ~rp : rp;
   assign rd_n     = release_blk ? 6'd0 : n;
   assign rd_avail = release_blk ? full[~rp] : (full[rp] && !done);
   assign load     = (!o_valid || i_ready) && rd_avail;
   assign zz_pos   = 6'd63 - rd_n;
   assign zz_bit   = {3'b000, zz_pos} * 9'd6;
   assign rd_addr  = ZZ_TABLE[zz_bit +: 6];

   always_ff @(posedge i_clk) begin
      if (wr_en) begin
         for (int j = 0; j < 8; j++) begin
            mem[wp][{3'(j), ic}] <= i_data[(7-j)*BW +: BW];
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_Reset) begin
      if (!i_Reset) begin
         ic         <= 3'd0;
         drop_q     <= 1'b0;
         wp         <= 1'b0;
         rp         <= 1'b0;
         full       <= 2'b00;
         n          <= 6'd0;
         done       <= 1'b0;
         o_data     <= '0;
         o_valid    <= 1'b0;
         o_last     <= 1'b0;
         o_overflow <= 1'b0;
      end else begin
         if (i_enable) begin
            ic <= ic + 3'd1;
            if (ic == 3'd0) begin
               drop_q <= !burst_ok;
               if (!burst_ok) begin
                  o_overflow <= 1'b1;
               end
            end
         end

         if (release_blk) begin
            full[rp] <= 1'b0;
            rp       <= ~rp;
            n        <= 6'd0;
            done     <= 1'b0;
         end

         if (wr_en && (ic == 3'd7)) begin
            full[wp] <= 1'b1;
            wp       <= ~wp;
         end

         if (load) begin
            o_data  <= mem[rd_bank][rd_addr];
            o_valid <= 1'b1;
            o_last  <= (rd_n == 6'd63);
            n       <= rd_n + 6'd1;
            done    <= (rd_n == 6'd63);
         end else if (i_ready) begin
            o_valid <= 1'b0;
            o_last  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_dct_zigzag_serializer.sv
// tb/tb_dct_zigzag_serializer.sv - directed bench with a zigzag-walk model and per-cycle output compare
module tb_dct_zigzag_serializer;
   localparam int BW = 12;

   typedef struct {
      logic [BW-1:0] d;
      logic          l;
   } beat_t;

   logic            i_clk = 1'b0;
   logic            i_Reset = 1'b1;
   logic [8*BW-1:0] i_data = '0;
   logic            i_enable = 1'b0;
   logic            i_ready = 1'b0;
   logic [BW-1:0]   o_data;
   logic            o_valid;
   logic            o_last;
   logic            o_overflow;

   beat_t         exp_q[$];
   int            zz[64];
   logic [BW-1:0] blk[64];
   logic [BW-1:0] beat_log[256];
   int            beat_cnt = 0;
   int            n_pass = 0;
   int            n_total = 0;
   int            rdy_mode = 0;
   int            rdy_cyc = 0;

   dct_zigzag_serializer #(.BW(BW)) dut (
      .i_clk      (i_clk),
      .i_Reset    (i_Reset),
      .i_data     (i_data),
      .i_enable   (i_enable),
      .i_ready    (i_ready),
      .o_data     (o_data),
      .o_valid    (o_valid),
      .o_last     (o_last),
      .o_overflow (o_overflow)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string name, input longint act, input longint req);
      n_total++;
      if (act == req) n_pass++;
      else $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
   endtask

   // Walk the anti-diagonals: even sums climb toward row 0, odd sums descend.
   function automatic void build_zz();
      int idx = 0;
      for (int s = 0; s < 15; s++) begin
         int lo = (s > 7) ? s - 7 : 0;
         int hi = (s < 7) ? s : 7;
         if (s % 2 == 0) begin
            for (int r = hi; r >= lo; r--) begin zz[idx] = r*8 + (s - r); idx++; end
         end else begin
            for (int r = lo; r <= hi; r++) begin zz[idx] = r*8 + (s - r); idx++; end
         end
      end
   endfunction

   function automatic void fill_block(input int base, input bit zero67);
      for (int r = 0; r < 64; r++) blk[r] = (zero67 && r >= 48) ? '0 : BW'(base + r);
   endfunction

   task automatic send_block(input bit gapped, input bit accepted);
      if (accepted) begin
         for (int k = 0; k < 64; k++) exp_q.push_back('{d: blk[zz[k]], l: (k == 63)});
      end
      for (int k = 0; k < 8; k++) begin
         i_enable = 1'b1;
         for (int j = 0; j < 8; j++) i_data[(7-j)*BW +: BW] = blk[j*8 + k];
         @(posedge i_clk); #1;
         i_enable = 1'b0;
         if (gapped) begin @(posedge i_clk); #1; end
      end
   endtask

   task automatic wait_drain(input string name);
      int c = 0;
      while ((exp_q.size() != 0 || o_valid) && c < 3000) begin
         @(posedge i_clk); #1;
         c++;
      end
      check(name, exp_q.size(), 0);
   endtask

   initial begin
      forever begin
         @(posedge i_clk); #1;
         if (rdy_mode == 1) begin
            i_ready = (rdy_cyc % 3 == 0);
            rdy_cyc++;
         end
      end
   end

   initial begin
      logic [BW-1:0] pd = '0;
      logic pv = 1'b0, pr = 1'b0, pl = 1'b0;
      forever begin
         @(negedge i_clk);
         if (!i_Reset) begin
            pv = 1'b0;
            continue;
         end
         if (pv && !pr) check("hold", {o_valid, o_last, o_data}, {1'b1, pl, pd});
         if (o_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_beat", 1, 0);
            end else begin
               check($sformatf("data[%0d]", beat_cnt), o_data, exp_q[0].d);
               check($sformatf("last[%0d]", beat_cnt), o_last, exp_q[0].l);
               if (i_ready) begin
                  void'(exp_q.pop_front());
                  if (beat_cnt < 256) beat_log[beat_cnt] = o_data;
                  beat_cnt++;
               end
            end
         end
         pv = o_valid; pr = i_ready; pd = o_data; pl = o_last;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int c;
      int v;
      build_zz();
      check("zz_pin3", zz[3], 16);
      check("zz_pin10", zz[10], 32);
      check("zz_pin60", zz[60], 47);
      check("zz_pin61", zz[61], 55);
      check("zz_pin63", zz[63], 63);

      #2 i_Reset = 1'b0;
      repeat (3) @(posedge i_clk);
      #1;
      check("rst_data", o_data, 0);
      check("rst_valid", o_valid, 0);
      check("rst_last", o_last, 0);
      check("rst_ovf", o_overflow, 0);
      i_Reset = 1'b1;
      @(posedge i_clk); #1;

      // Single block, element (j,k) = 8j+k+1
      i_ready = 1'b1;
      fill_block(1, 0);
      beat_cnt = 0;
      send_block(0, 1);
      check("lat_edge_t", o_valid, 0);
      @(posedge i_clk); #1;
      check("lat_edge_t1", o_valid, 1);
      check("first_data", o_data, 1);
      wait_drain("drain_single");
      check("single_count", beat_cnt, 64);
      check("lit0", beat_log[0], 1);
      check("lit1", beat_log[1], 2);
      check("lit2", beat_log[2], 9);
      check("lit3", beat_log[3], 17);
      check("lit58", beat_log[58], 62);
      check("lit59", beat_log[59], 55);
      check("lit60", beat_log[60], 48);
      check("lit61", beat_log[61], 56);
      check("lit62", beat_log[62], 63);
      check("lit63", beat_log[63], 64);

      // Same block with stalls
      beat_cnt = 0;
      rdy_cyc = 0;
      rdy_mode = 1;
      send_block(0, 1);
      wait_drain("drain_stall");
      rdy_mode = 0;
      i_ready = 1'b1;
      check("stall_count", beat_cnt, 64);
      check("stall_lit5", beat_log[5], 3);

      // Two blocks back-to-back
      fill_block(12'h100, 0);
      send_block(0, 1);
      fill_block(12'h200, 0);
      fork
         send_block(0, 1);
         begin
            c = 0;
            v = 0;
            @(negedge i_clk);
            while (!o_valid && c < 30) begin @(negedge i_clk); c++; end
            for (int i = 0; i < 128; i++) begin
               if (o_valid) v++;
               @(negedge i_clk);
            end
            check("no_gap", v, 128);
         end
      join
      wait_drain("drain_b2b");
      check("b2b_ovf", o_overflow, 0);

      // Three bursts with no downstream acceptance
      i_ready = 1'b0;
      fill_block(12'h400, 0);
      send_block(0, 1);
      fill_block(12'h500, 0);
      send_block(0, 1);
      check("ovf_before", o_overflow, 0);
      fill_block(12'h600, 0);
      send_block(0, 0);
      check("ovf_after", o_overflow, 1);
      repeat (5) @(posedge i_clk);
      #1;
      check("held_valid", o_valid, 1);
      check("held_data", o_data, 12'h400);
      beat_cnt = 0;
      i_ready = 1'b1;
      wait_drain("drain_ovf");
      check("ovf_count", beat_cnt, 128);
      check("ovf_b2_first", beat_log[64], 12'h500);
      v = 0;
      repeat (10) begin @(posedge i_clk); #1; if (o_valid) v++; end
      check("no_block3", v, 0);
      check("ovf_sticky", o_overflow, 1);

      // Upstream-style block, rows 6/7 zero, gapped enable
      fill_block(12'h300, 1);
      beat_cnt = 0;
      send_block(1, 1);
      wait_drain("drain_gap");
      check("gap_first", beat_log[0], 12'h300);
      check("gap_n61", beat_log[61], 0);
      check("gap_n62", beat_log[62], 0);
      check("gap_n63", beat_log[63], 0);

      // Reset mid-drain, then mid-burst, then a fresh block
      fill_block(1, 0);
      beat_cnt = 0;
      send_block(0, 1);
      c = 0;
      while (beat_cnt < 20 && c < 500) begin @(posedge i_clk); c++; end
      check("beat20_reached", beat_cnt >= 20, 1);
      #3 i_Reset = 1'b0;
      #1;
      check("mid_rst_data", o_data, 0);
      check("mid_rst_valid", o_valid, 0);
      check("mid_rst_last", o_last, 0);
      check("mid_rst_ovf", o_overflow, 0);
      exp_q.delete();
      repeat (2) @(posedge i_clk);
      #1 i_Reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         i_enable = 1'b1;
         i_data = {8{12'hABC}};
         @(posedge i_clk); #1;
      end
      i_enable = 1'b0;
      i_Reset = 1'b0;
      @(posedge i_clk); #1;
      i_Reset = 1'b1;
      check("burst_rst_valid", o_valid, 0);
      beat_cnt = 0;
      send_block(0, 1);
      wait_drain("drain_after_rst");
      check("rst_count", beat_cnt, 64);
      check("rst_lit0", beat_log[0], 1);
      check("rst_lit2", beat_log[2], 9);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
